// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions for the memory-stage store buffer.
// Contents: instruction_type encoding for stores, funct3 store sizes,
// per-entry state encoding and the buffered store payload struct.
package pipeline_pkg;

  localparam int unsigned SB_WORD_SIZE    = 32;
  localparam int unsigned SB_ROB_ID_WIDTH = 7;

  localparam logic [1:0] INSTR_STORE = 2'd2;

  localparam logic [2:0] F3_SB = 3'd0;
  localparam logic [2:0] F3_SH = 3'd1;
  localparam logic [2:0] F3_SW = 3'd2;

  typedef enum logic [1:0] {
    FREE      = 2'd0,
    PENDING   = 2'd1,
    COMMITTED = 2'd2
  } entry_state_t;

  // Payload of one buffered store
  typedef struct packed {
    logic [SB_WORD_SIZE-1:0]    addr;
    logic [SB_WORD_SIZE-1:0]    data;
    logic [2:0]                 funct3;
    logic [SB_ROB_ID_WIDTH-1:0] rob_id;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_ptr.sv
// Head/tail/occupancy bookkeeping for the store buffer ring.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   push, pop             allocate at tail / retire at head this cycle
//   flush, committed_cnt  rewind tail to head + committed_cnt on flush
//   head, tail, count     registered ring pointers and occupancy
module store_buffer_ptr #(
  parameter int unsigned ENTRIES = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [$clog2(ENTRIES):0]     committed_cnt,
  output logic [$clog2(ENTRIES)-1:0]   head,
  output logic [$clog2(ENTRIES)-1:0]   tail,
  output logic [$clog2(ENTRIES):0]     count
);

  localparam int unsigned PTR_W = $clog2(ENTRIES);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  // ENTRIES is a power of two, so pointers wrap naturally at PTR_W bits.
  // On flush, committed_cnt already includes a same-cycle commit and still
  // counts the entry being drained, so the survivors end at head+committed_cnt.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (pop) r_head <= r_head + PTR_W'(1);
      if (flush) begin
        r_tail  <= r_head + committed_cnt[PTR_W-1:0];
        r_count <= committed_cnt - CNT_W'(pop);
      end else begin
        if (push) r_tail <= r_tail + PTR_W'(1);
        r_count <= r_count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  assign head  = r_head;
  assign tail  = r_tail;
  assign count = r_count;

endmodule

// File: rtl/store_buffer.sv
// In-order store buffer between the E/M register and the data cache.
// Captures stores, holds them until the ROB commits, then drains the head
// entry to the cache over a valid/ready request.
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   valid, instruction_type, funct3,   incoming E/M stage fields
//   aluResult, s2, rob_id
//   stall                              buffer full, E/M must hold
//   commit_valid, commit_rob_id        ROB commit of one store
//   flush                              drop all uncommitted entries
//   cache_req_*                        head entry request to the cache
// Optional (define STORE_BUFFER_FORWARD_EN):
//   ld_addr, ld_hit, ld_data           word store-to-load forwarding lookup
module store_buffer
  import pipeline_pkg::*;
#(
  parameter int unsigned WORD_SIZE    = SB_WORD_SIZE,
  parameter int unsigned ENTRIES      = 4,
  parameter int unsigned ROB_ID_WIDTH = SB_ROB_ID_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    valid,
  input  logic [1:0]              instruction_type,
  input  logic [2:0]              funct3,
  input  logic [WORD_SIZE-1:0]    aluResult,
  input  logic [WORD_SIZE-1:0]    s2,
  input  logic [ROB_ID_WIDTH-1:0] rob_id,
  output logic                    stall,
  input  logic                    commit_valid,
  input  logic [ROB_ID_WIDTH-1:0] commit_rob_id,
  input  logic                    flush,
  output logic                    cache_req_valid,
  output logic [WORD_SIZE-1:0]    cache_req_addr,
  output logic [WORD_SIZE-1:0]    cache_req_data,
  output logic [2:0]              cache_req_funct3,
  input  logic                    cache_req_ready
`ifdef STORE_BUFFER_FORWARD_EN
  ,
  input  logic [WORD_SIZE-1:0]    ld_addr,
  output logic                    ld_hit,
  output logic [WORD_SIZE-1:0]    ld_data
`endif
);

  localparam int unsigned PTR_W = $clog2(ENTRIES);
  localparam int unsigned CNT_W = PTR_W + 1;

  sb_entry_t    r_entry [ENTRIES];
  entry_state_t r_state [ENTRIES];
  entry_state_t w_state_nxt [ENTRIES];

  logic [PTR_W-1:0]   w_head;
  logic [PTR_W-1:0]   w_tail;
  logic [CNT_W-1:0]   w_count;
  logic [CNT_W-1:0]   w_committed_cnt;
  logic [ENTRIES-1:0] w_commit_hit;
  logic               w_push;
  logic               w_pop;

  assign stall  = (w_count == CNT_W'(ENTRIES));
  assign w_push = valid && (instruction_type == INSTR_STORE) && !stall && !flush;
  assign w_pop  = cache_req_valid && cache_req_ready;

  // Head request is driven from registered entry state only
  assign cache_req_valid  = (r_state[w_head] == COMMITTED);
  assign cache_req_addr   = r_entry[w_head].addr;
  assign cache_req_data   = r_entry[w_head].data;
  assign cache_req_funct3 = r_entry[w_head].funct3;

  // Commit CAM and count of entries that remain committed after this cycle's commit
  always_comb begin
    w_commit_hit    = '0;
    w_committed_cnt = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      w_commit_hit[i] = commit_valid && (r_state[i] == PENDING) &&
                        (r_entry[i].rob_id == commit_rob_id);
      if ((r_state[i] == COMMITTED) || w_commit_hit[i])
        w_committed_cnt = w_committed_cnt + CNT_W'(1);
    end
  end

  // Per-entry state: commit, then flush, then drain, then allocate
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      w_state_nxt[i] = r_state[i];
      if (w_commit_hit[i]) w_state_nxt[i] = COMMITTED;
      if (flush && (w_state_nxt[i] == PENDING)) w_state_nxt[i] = FREE;
      if (w_pop && (w_head == PTR_W'(i))) w_state_nxt[i] = FREE;
      if (w_push && (w_tail == PTR_W'(i))) w_state_nxt[i] = PENDING;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_state[i] <= FREE;
        r_entry[i] <= '0;
      end
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_state[i] <= w_state_nxt[i];
        if (w_push && (w_tail == PTR_W'(i))) begin
          r_entry[i].addr   <= aluResult;
          r_entry[i].data   <= s2;
          r_entry[i].funct3 <= funct3;
          r_entry[i].rob_id <= rob_id;
        end
      end
    end
  end

  store_buffer_ptr #(
    .ENTRIES (ENTRIES)
  ) u_ptr (
    .clk           (clk),
    .reset         (reset),
    .push          (w_push),
    .pop           (w_pop),
    .flush         (flush),
    .committed_cnt (w_committed_cnt),
    .head          (w_head),
    .tail          (w_tail),
    .count         (w_count)
  );

`ifdef STORE_BUFFER_FORWARD_EN
  localparam logic [WORD_SIZE-1:0] WORD_MASK = ~WORD_SIZE'(3);

  logic [PTR_W-1:0] w_fwd_idx;

  // Walk from oldest to youngest so the youngest matching word store wins
  always_comb begin
    ld_hit    = 1'b0;
    ld_data   = '0;
    w_fwd_idx = '0;
    for (int k = 0; k < ENTRIES; k++) begin
      w_fwd_idx = w_head + PTR_W'(k);
      if ((r_state[w_fwd_idx] != FREE) && (r_entry[w_fwd_idx].funct3 == F3_SW) &&
          ((r_entry[w_fwd_idx].addr & WORD_MASK) == (ld_addr & WORD_MASK))) begin
        ld_hit  = 1'b1;
        ld_data = r_entry[w_fwd_idx].data;
      end
    end
  end
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Directed, table-driven bench for store_buffer (default 32-bit, 4 entries).
module tb_store_buffer;
  import pipeline_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid;
  logic [1:0]  instruction_type;
  logic [2:0]  funct3;
  logic [31:0] aluResult;
  logic [31:0] s2;
  logic [6:0]  rob_id;
  logic        stall;
  logic        commit_valid;
  logic [6:0]  commit_rob_id;
  logic        flush;
  logic        cache_req_valid;
  logic [31:0] cache_req_addr;
  logic [31:0] cache_req_data;
  logic [2:0]  cache_req_funct3;
  logic        cache_req_ready;
`ifdef STORE_BUFFER_FORWARD_EN
  logic [31:0] ld_addr = '0;
  logic        ld_hit;
  logic [31:0] ld_data;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  store_buffer dut (
    .clk              (clk),
    .reset            (reset),
    .valid            (valid),
    .instruction_type (instruction_type),
    .funct3           (funct3),
    .aluResult        (aluResult),
    .s2               (s2),
    .rob_id           (rob_id),
    .stall            (stall),
    .commit_valid     (commit_valid),
    .commit_rob_id    (commit_rob_id),
    .flush            (flush),
    .cache_req_valid  (cache_req_valid),
    .cache_req_addr   (cache_req_addr),
    .cache_req_data   (cache_req_data),
    .cache_req_funct3 (cache_req_funct3),
    .cache_req_ready  (cache_req_ready)
`ifdef STORE_BUFFER_FORWARD_EN
    ,
    .ld_addr          (ld_addr),
    .ld_hit           (ld_hit),
    .ld_data          (ld_data)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        vld;
    logic [1:0]  ty;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] data;
    logic [6:0]  rob;
    logic        cv;
    logic [6:0]  crob;
    logic        fl;
    logic        rdy;
    logic        e_stall;
    logic        e_rv;
    logic [31:0] e_addr;
    logic [31:0] e_data;
    logic [2:0]  e_f3;
    logic [2:0]  e_cnt;
    logic [1:0]  e_tail;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic rst, input logic vld, input logic [1:0] ty, input logic [2:0] f3,
    input logic [31:0] addr, input logic [31:0] data, input logic [6:0] rob,
    input logic cv, input logic [6:0] crob, input logic fl, input logic rdy,
    input logic e_stall, input logic e_rv, input logic [31:0] e_addr,
    input logic [31:0] e_data, input logic [2:0] e_f3, input logic [2:0] e_cnt,
    input logic [1:0] e_tail);
    vec_t v;
    v.rst = rst; v.vld = vld; v.ty = ty; v.f3 = f3; v.addr = addr; v.data = data;
    v.rob = rob; v.cv = cv; v.crob = crob; v.fl = fl; v.rdy = rdy;
    v.e_stall = e_stall; v.e_rv = e_rv; v.e_addr = e_addr; v.e_data = e_data;
    v.e_f3 = e_f3; v.e_cnt = e_cnt; v.e_tail = e_tail;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs, clock, then settle just after the edge
  task automatic step(input logic rst, input logic vld, input logic [1:0] ty,
                      input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data,
                      input logic [6:0] rob, input logic cv, input logic [6:0] crob,
                      input logic fl, input logic rdy);
    reset = rst; valid = vld; instruction_type = ty; funct3 = f3;
    aluResult = addr; s2 = data; rob_id = rob;
    commit_valid = cv; commit_rob_id = crob; flush = fl; cache_req_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_req(input string tag, input logic e_rv, input logic [31:0] e_addr,
                         input logic [31:0] e_data, input logic [2:0] e_f3);
    chk({tag, " req_valid"}, 32'(cache_req_valid), 32'(e_rv));
    chk({tag, " req_addr"},  cache_req_addr, e_addr);
    chk({tag, " req_data"},  cache_req_data, e_data);
    chk({tag, " req_funct3"}, 32'(cache_req_funct3), 32'(e_f3));
  endtask

  task automatic chk_occ(input string tag, input logic e_stall, input logic [2:0] e_cnt,
                         input logic [1:0] e_tail);
    chk({tag, " stall"}, 32'(stall), 32'(e_stall));
    chk({tag, " count"}, 32'(dut.w_count), 32'(e_cnt));
    chk({tag, " tail"},  32'(dut.w_tail), 32'(e_tail));
  endtask

  initial begin
    // rst vld ty f3 addr data rob cv crob fl rdy | stall rv addr data f3 cnt tail
    // Single store: held until commit, then held stable until ready
    vecs.push_back(mk(0,1,2,2,32'h100,32'hDEADBEEF,5, 0,0,0,0, 0,0,32'h100,32'hDEADBEEF,2,1,1));
    vecs.push_back(mk(0,0,0,0,0,0,0,                  0,0,0,1, 0,0,32'h100,32'hDEADBEEF,2,1,1));
    vecs.push_back(mk(0,0,0,0,0,0,0,                  1,5,0,0, 0,1,32'h100,32'hDEADBEEF,2,1,1));
    vecs.push_back(mk(0,0,0,0,0,0,0,                  0,0,0,0, 0,1,32'h100,32'hDEADBEEF,2,1,1));
    vecs.push_back(mk(0,0,0,0,0,0,0,                  0,0,0,0, 0,1,32'h100,32'hDEADBEEF,2,1,1));
    vecs.push_back(mk(0,0,0,0,0,0,0,                  0,0,0,1, 0,0,0,0,0,0,1));
    // Non-store and invalid inputs are ignored
    vecs.push_back(mk(0,1,0,2,32'h44,32'h55,7,        0,0,0,1, 0,0,0,0,0,0,1));
    vecs.push_back(mk(0,0,2,2,32'h44,32'h55,7,        0,0,0,1, 0,0,0,0,0,0,1));
    vecs.push_back(mk(1,0,0,0,0,0,0,                  0,0,0,0, 0,0,0,0,0,0,0));
    // Fill to full; funct3=7 forwarded unchanged
    vecs.push_back(mk(0,1,2,0,32'h10,32'hA1,1,        0,0,0,0, 0,0,32'h10,32'hA1,0,1,1));
    vecs.push_back(mk(0,1,2,1,32'h14,32'hA2,2,        0,0,0,0, 0,0,32'h10,32'hA1,0,2,2));
    vecs.push_back(mk(0,1,2,7,32'h18,32'hA3,3,        0,0,0,0, 0,0,32'h10,32'hA1,0,3,3));
    vecs.push_back(mk(0,1,2,2,32'h1C,32'hA4,4,        0,0,0,0, 1,0,32'h10,32'hA1,0,4,0));
    vecs.push_back(mk(0,1,2,2,32'h20,32'hA6,6,        0,0,0,0, 1,0,32'h10,32'hA1,0,4,0));
    vecs.push_back(mk(0,1,2,2,32'h20,32'hA6,6,        1,1,0,0, 1,1,32'h10,32'hA1,0,4,0));
    // Drain while full: push still refused this cycle
    vecs.push_back(mk(0,1,2,2,32'h20,32'hA6,6,        0,0,0,1, 0,0,32'h14,32'hA2,1,3,0));
    vecs.push_back(mk(0,1,2,2,32'h20,32'hA6,6,        0,0,0,0, 1,0,32'h14,32'hA2,1,4,1));
    // Commit and drain everything back out in order
    vecs.push_back(mk(0,0,0,0,0,0,0,                  1,2,0,1, 1,1,32'h14,32'hA2,1,4,1));
    vecs.push_back(mk(0,0,0,0,0,0,0,                  1,3,0,1, 0,1,32'h18,32'hA3,7,3,1));
    vecs.push_back(mk(0,0,0,0,0,0,0,                  1,4,0,1, 0,1,32'h1C,32'hA4,2,2,1));
    vecs.push_back(mk(0,0,0,0,0,0,0,                  1,6,0,1, 0,1,32'h20,32'hA6,2,1,1));
    vecs.push_back(mk(0,0,0,0,0,0,0,                  0,0,0,1, 0,0,32'h14,32'hA2,1,0,1));

    // Reset state
    step(1,0,0,0,0,0,0,0,0,0,0);
    step(1,0,0,0,0,0,0,0,0,0,0);
    chk_occ("reset", 0, 0, 0);
    chk_req("reset", 0, 0, 0, 0);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].vld, vecs[i].ty, vecs[i].f3, vecs[i].addr, vecs[i].data,
           vecs[i].rob, vecs[i].cv, vecs[i].crob, vecs[i].fl, vecs[i].rdy);
      chk_occ($sformatf("v%0d", i), vecs[i].e_stall, vecs[i].e_cnt, vecs[i].e_tail);
      chk_req($sformatf("v%0d", i), vecs[i].e_rv, vecs[i].e_addr, vecs[i].e_data, vecs[i].e_f3);
    end

    // Flush with a same-cycle commit: 10 and 11 survive, 12 and the push of 13 are dropped
    step(0,1,INSTR_STORE,F3_SW,32'h30,32'hB0,10, 0,0,0,0);
    step(0,1,INSTR_STORE,F3_SW,32'h34,32'hB1,11, 0,0,0,0);
    step(0,1,INSTR_STORE,F3_SW,32'h38,32'hB2,12, 0,0,0,0);
    chk_occ("fl fill", 0, 3, 0);
    step(0,0,0,0,0,0,0, 1,10,0,0);
    chk_req("fl c10", 1, 32'h30, 32'hB0, F3_SW);
    step(0,1,INSTR_STORE,F3_SW,32'h40,32'hB3,13, 1,11,1,0);
    chk_occ("fl flush", 0, 2, 3);
    chk_req("fl flush", 1, 32'h30, 32'hB0, F3_SW);
    // Drain plus push in the same cycle leaves count unchanged
    step(0,1,INSTR_STORE,F3_SB,32'h3C,32'hB4,14, 0,0,0,1);
    chk_occ("fl pushpop", 0, 2, 0);
    chk_req("fl pushpop", 1, 32'h34, 32'hB1, F3_SW);
    step(0,0,0,0,0,0,0, 0,0,0,1);
    chk_occ("fl pop11", 0, 1, 0);
    chk_req("fl pop11", 0, 32'h3C, 32'hB4, F3_SB);
    // Flush with nothing committed rewinds tail to head
    step(0,0,0,0,0,0,0, 0,0,1,1);
    chk_occ("fl empty", 0, 0, 3);

    // Reset while a request is outstanding
    step(0,1,INSTR_STORE,F3_SH,32'h50,32'hC0,20, 0,0,0,0);
    step(0,0,0,0,0,0,0, 1,20,0,0);
    chk_req("rd pre", 1, 32'h50, 32'hC0, F3_SH);
    step(1,0,0,0,0,0,0, 0,0,0,1);
    chk_req("rd post", 0, 0, 0, 0);
    chk_occ("rd post", 0, 0, 0);

`ifdef STORE_BUFFER_FORWARD_EN
    step(0,0,0,0,0,0,0, 0,0,0,0);
    ld_addr = 32'h200;
    #1;
    chk("fwd empty hit", 32'(ld_hit), 0);
    step(0,1,INSTR_STORE,F3_SW,32'h200,32'h11,30, 0,0,0,0);
    step(0,1,INSTR_STORE,F3_SW,32'h200,32'h22,31, 0,0,0,0);
    step(0,1,INSTR_STORE,F3_SB,32'h200,32'h33,32, 0,0,0,0);
    ld_addr = 32'h202;
    #1;
    chk("fwd young hit", 32'(ld_hit), 1);
    chk("fwd young data", ld_data, 32'h22);
    ld_addr = 32'h204;
    #1;
    chk("fwd miss hit", 32'(ld_hit), 0);
    chk("fwd miss data", ld_data, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
Memory-stage consumer of the Execute/Memory pipeline register outputs. Captures valid store instructions (address = aluResult, data = s2, size = funct3, rob_id) into an in-order FIFO. Holds each entry until the ROB commits it, then drains it to the data cache through a valid/ready request. Raises stall back toward the E/M register when full.

Parameters:
WORD_SIZE, 32, width of address and data words
ENTRIES, 4, number of buffer slots (power of two, >=2)
ROB_ID_WIDTH, 7, width of ROB identifiers

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
valid  in  1  E/M register valid_out
instruction_type  in  2  E/M instruction_type_out
funct3  in  3  store size (0=SB, 1=SH, 2=SW)
aluResult  in  WORD_SIZE  store byte address
s2  in  WORD_SIZE  store data
rob_id  in  ROB_ID_WIDTH  ROB tag of the incoming store
stall  out  1  buffer full; E/M register must hold
commit_valid  in  1  ROB commits one store this cycle
commit_rob_id  in  ROB_ID_WIDTH  tag being committed
flush  in  1  discard all uncommitted entries
cache_req_valid  out  1  head entry presented to cache
cache_req_addr  out  WORD_SIZE  head address
cache_req_data  out  WORD_SIZE  head data
cache_req_funct3  out  3  head size
cache_req_ready  in  1  cache accepts request this cycle

Behaviour:
- Interface decision: one clock, clk; reset is synchronous and active-high, port reset.
- Reset: all entries FREE, head=tail=0, count=0. stall=0 and cache_req_valid=0 in the cycle after reset. Request data outputs are 0.
- Per-entry state: FREE -> PENDING (push) -> COMMITTED (commit match) -> FREE (drain).
- Push: occurs when valid && instruction_type==INSTR_STORE && !stall && !flush.
  - Writes {aluResult, s2, funct3, rob_id} at tail, state PENDING.
  - tail advances, wrapping modulo ENTRIES.
  - Non-store or invalid inputs are ignored.
- stall = (count==ENTRIES), driven combinationally from registered count.
  - No push while full, even if a drain happens in the same cycle.
- Commit: on commit_valid, the PENDING entry whose rob_id equals commit_rob_id becomes COMMITTED.
  - No match: no effect.
  - Commits arrive in program order, so COMMITTED entries are always contiguous from head.
- Drain: cache_req_valid = head entry is COMMITTED. Request fields show the head entry.
  - On cache_req_valid && cache_req_ready: head entry becomes FREE, head advances.
  - Request stays asserted and stable until accepted.
- flush: every PENDING entry becomes FREE; tail = head + committed_count.
  - A push in the same cycle is dropped.
  - A commit in the same cycle is applied before the flush, so that entry survives.
  - A drain in the same cycle proceeds normally.
- Simultaneous push and drain: count unchanged.
- Simultaneous commit of the head entry and drain: the drain begins the next cycle (cache_req_valid uses registered state).
- Pointer width is log2(ENTRIES). count width is log2(ENTRIES)+1.
- funct3 values other than 0/1/2 are stored and forwarded unchanged.
- Reset mid-drain: request dropped; cache_req_valid=0 next cycle.

Optional Feature:
STORE_BUFFER_FORWARD_EN.
- When defined, adds three ports:
  - ld_addr (in, WORD_SIZE)
  - ld_hit (out, 1)
  - ld_data (out, WORD_SIZE)
- Combinational search of all non-FREE entries for funct3==SW and addr[WORD_SIZE-1:2]==ld_addr[WORD_SIZE-1:2].
- The youngest match (closest to tail) wins: ld_hit=1, ld_data=that entry's data. Otherwise ld_hit=0, ld_data=0.
- When not defined: ports absent, no search logic.

Decomposition:
- Shared package (pipeline_pkg):
  - INSTR_STORE=2'd2 instruction_type encoding
  - funct3 size constants SB/SH/SW
  - entry_state_t enum {FREE, PENDING, COMMITTED}
  - sb_entry_t struct {addr, data, funct3, rob_id}
- One natural sub-module: store_buffer_ptr, handling head/tail/count bookkeeping with wrap and the flush rewind. The entry array and the commit CAM stay in store_buffer.

Test Plan:
1. Reset then push store (type=2, addr=0x100, data=0xDEADBEEF, funct3=2, rob=5) -> count=1, cache_req_valid stays 0 with no commit.
2. Commit rob 5 with cache_req_ready=0 for 3 cycles, then 1 -> cache_req_valid=1 from cycle after commit, fields stable at 0x100/0xDEADBEEF/2, pops on ready; count=0.
3. Push 4 stores (rob 1-4), no commit -> stall=1; 5th store (rob 6) is ignored. Commit rob 1 and drain -> stall=0, then rob 6 is accepted at wrapped tail slot 0.
4. Push rob 10, 11, 12; commit 10; flush in the same cycle as commit of 11 -> 10 and 11 remain and drain in order; 12 is discarded; tail = head+2.
5. Push with valid=1, type=0 (non-store) and with valid=0, type=2 -> no entry allocated, count unchanged.
6. With STORE_BUFFER_FORWARD_EN: push SW 0x200/0x11 then SW 0x200/0x22, ld_addr=0x202 -> ld_hit=1, ld_data=0x22; ld_addr=0x204 -> ld_hit=0.
